// File: rtl/fifo_line_pkg.sv
// Shared types and size helpers for the capture-word line packer.
package fifo_line_pkg;
  localparam int                 DEF_IN_W     = 64;
  localparam int                 DEF_LINE_W   = 256;
  localparam logic [DEF_IN_W-1:0] DEF_PAD_WORD = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [2:0] {RUN, FLUSH, DRAIN, DONE, REARM} pk_state_e;

  function automatic int words_per_line(input int in_w, input int line_w);
    return line_w / in_w;
  endfunction

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/line_out_slot.sv
// Single-entry valid/ready holding register for finished lines.
module line_out_slot
  import fifo_line_pkg::*;
#(
  parameter int DATA_W = DEF_LINE_W,
  parameter int FILL_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic [FILL_W-1:0] i_fill,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [FILL_W-1:0] o_fill,
  output logic              o_free
);
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [FILL_W-1:0] r_fill;

  // A load wins over a same-cycle accept: the old line leaves, the new one lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_fill  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_fill  <= i_fill;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_fill  = r_fill;
  assign o_free  = !r_valid || i_ready;
endmodule

// File: rtl/fifo_line_packer.sv
// Packs IN_W capture words into LINE_W lines; pads and emits a partial line on flush.
module fifo_line_packer
  import fifo_line_pkg::*;
#(
  parameter int              IN_W     = DEF_IN_W,
  parameter int              LINE_W   = DEF_LINE_W,
  parameter logic [IN_W-1:0] PAD_WORD = DEF_PAD_WORD
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [IN_W-1:0]               in_data,
  output logic                          in_ready,
  output logic                          opkwenb,
  input  logic                          flush_i,
  output logic                          flush_done,
  output logic                          out_valid,
  output logic [LINE_W-1:0]             out_data,
  input  logic                          out_ready,
  output logic [$clog2(LINE_W/IN_W):0]  out_fill,
  output logic [15:0]                   flush_cnt
);
  localparam int N      = words_per_line(IN_W, LINE_W);
  localparam int CNT_W  = cnt_w(N);
  localparam int FILL_W = CNT_W + 1;

  pk_state_e                r_state, w_next;
  logic [N-1:0][IN_W-1:0]   r_acc, w_full, w_pad;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_opkwenb;
  logic [15:0]              r_flush_cnt;
  logic                     w_xfer, w_last, w_free, w_pad_load, w_load;
  logic [LINE_W-1:0]        w_load_data;
  logic [FILL_W-1:0]        w_load_fill;

  // out_ready is deliberately kept out of in_ready; a full last slot stalls on out_valid alone.
  assign w_last     = (r_cnt == CNT_W'(N-1));
  assign in_ready   = rst_n && (r_state == RUN) && !flush_i && (!w_last || !out_valid);
  assign w_xfer     = in_valid && in_ready;
  assign w_pad_load = (r_state == FLUSH) && (r_cnt != '0) && w_free;
  assign w_load     = (w_xfer && w_last) || w_pad_load;

  always_comb begin
    w_full      = r_acc;
    w_full[N-1] = in_data;
    w_pad       = r_acc;
    for (int k = 0; k < N; k++)
      if (CNT_W'(k) >= r_cnt) w_pad[k] = PAD_WORD;
  end

  assign w_load_data = w_pad_load ? w_pad : w_full;
  assign w_load_fill = w_pad_load ? {1'b0, r_cnt} : FILL_W'(N);

  always_comb begin
    w_next = r_state;
    case (r_state)
      RUN:     if (flush_i) w_next = FLUSH;
      FLUSH:   if (r_cnt == '0) w_next = DONE;
               else if (w_free) w_next = DRAIN;
      DRAIN:   if (out_valid && out_ready) w_next = DONE;
      DONE:    w_next = REARM;
      REARM:   if (!flush_i) w_next = RUN;
      default: w_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_opkwenb   <= 1'b0;
      r_flush_cnt <= '0;
    end else begin
      r_state   <= w_next;
      r_opkwenb <= w_xfer;
      if (w_xfer) begin
        r_acc[r_cnt] <= in_data;
        r_cnt        <= w_last ? '0 : r_cnt + 1'b1;
      end else if (w_pad_load) begin
        r_cnt <= '0;
        if (r_flush_cnt != 16'hFFFF) r_flush_cnt <= r_flush_cnt + 16'd1;
      end
    end
  end

  assign opkwenb    = r_opkwenb;
  assign flush_done = (r_state == DONE);
  assign flush_cnt  = r_flush_cnt;

  line_out_slot #(.DATA_W(LINE_W), .FILL_W(FILL_W)) u_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_data  (w_load_data),
    .i_fill  (w_load_fill),
    .i_ready (out_ready),
    .o_valid (out_valid),
    .o_data  (out_data),
    .o_fill  (out_fill),
    .o_free  (w_free)
  );
endmodule

// File: tb/tb_fifo_line_packer.sv
// Directed bench for fifo_line_packer: packing, flush paths, backpressure, reset.
module tb_fifo_line_packer;
  localparam logic [63:0] PAD = 64'hFFFF_FFFF_FFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, opkwenb, flush_i, flush_done;
  logic         out_valid, out_ready;
  logic [63:0]  in_data;
  logic [255:0] out_data;
  logic [2:0]   out_fill;
  logic [15:0]  flush_cnt;

  int vec = 0, errs = 0, opk_cnt = 0, fd_cnt = 0;
  logic [255:0] q_data[$];
  logic [2:0]   q_fill[$];

  always #5 clk = ~clk;

  fifo_line_packer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .opkwenb(opkwenb), .flush_i(flush_i), .flush_done(flush_done), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .out_fill(out_fill), .flush_cnt(flush_cnt)
  );

  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_fill.push_back(out_fill);
    end
    if (opkwenb) opk_cnt++;
    if (flush_done) fd_cnt++;
  end

  function automatic logic [255:0] mk(input logic [63:0] w3, w2, w1, w0);
    return {w3, w2, w1, w0};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush_i = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    vec++; if (in_ready !== 1'b0) begin errs++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    vec++; if ({out_valid, opkwenb, flush_done} !== 3'b000) begin
      errs++; $display("FAIL rst_flags got %b want 000", {out_valid, opkwenb, flush_done}); end
    vec++; if (out_data !== '0 || out_fill !== 3'd0 || flush_cnt !== 16'd0) begin
      errs++; $display("FAIL rst_regs got %h/%0d/%0d want 0/0/0", out_data, out_fill, flush_cnt); end
    rst_n = 1'b1;
    #1;
    vec++; if (in_ready !== 1'b1) begin errs++; $display("FAIL run_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_pack();
    int q0 = q_data.size();
    int o0 = opk_cnt;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 4) begin
        vec++; if (out_valid !== 1'b1 || out_data !== mk(3, 2, 1, 0)) begin
          errs++; $display("FAIL pack_latency got %b %h want 1 %h", out_valid, out_data, mk(3, 2, 1, 0)); end
      end
      in_valid = 1'b1; in_data = 64'(i);
      #1;
      vec++; if (in_ready !== 1'b1) begin errs++; $display("FAIL pack_ready[%0d] got %b want 1", i, in_ready); end
    end
    @(negedge clk); in_valid = 1'b0;
    repeat (3) @(negedge clk);
    vec++; if (q_data.size() != q0 + 2) begin
      errs++; $display("FAIL pack_lines got %0d want %0d", q_data.size() - q0, 2); end
    else begin
      vec++; if (q_data[q0] !== mk(3, 2, 1, 0) || q_fill[q0] !== 3'd4) begin
        errs++; $display("FAIL pack_line0 got %h/%0d want %h/4", q_data[q0], q_fill[q0], mk(3, 2, 1, 0)); end
      vec++; if (q_data[q0+1] !== mk(7, 6, 5, 4) || q_fill[q0+1] !== 3'd4) begin
        errs++; $display("FAIL pack_line1 got %h/%0d want %h/4", q_data[q0+1], q_fill[q0+1], mk(7, 6, 5, 4)); end
    end
    vec++; if (opk_cnt - o0 != 8) begin errs++; $display("FAIL pack_opkwenb got %0d want 8", opk_cnt - o0); end
    vec++; if (flush_cnt !== 16'd0) begin errs++; $display("FAIL pack_flush_cnt got %0d want 0", flush_cnt); end
  endtask

  task automatic test_flush_partial();
    int f0 = fd_cnt;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); in_valid = 1'b1; in_data = 64'hA + 64'(i);
    end
    @(negedge clk); in_valid = 1'b0; flush_i = 1'b1;
    #1;
    vec++; if (in_ready !== 1'b0) begin errs++; $display("FAIL fp_ready_t got %b want 0", in_ready); end
    @(negedge clk);
    vec++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errs++; $display("FAIL fp_t1 got rdy=%b vld=%b want 0 0", in_ready, out_valid); end
    @(negedge clk);
    vec++; if (out_valid !== 1'b1 || out_data !== mk(PAD, 64'hC, 64'hB, 64'hA) || out_fill !== 3'd3) begin
      errs++; $display("FAIL fp_line got %b %h/%0d want 1 %h/3", out_valid, out_data, out_fill, mk(PAD, 64'hC, 64'hB, 64'hA)); end
    vec++; if (in_ready !== 1'b0 || flush_done !== 1'b0) begin
      errs++; $display("FAIL fp_t2 got rdy=%b done=%b want 0 0", in_ready, flush_done); end
    @(negedge clk);
    vec++; if (flush_done !== 1'b1 || flush_cnt !== 16'd1 || in_ready !== 1'b0) begin
      errs++; $display("FAIL fp_done got done=%b cnt=%0d rdy=%b want 1 1 0", flush_done, flush_cnt, in_ready); end
    @(negedge clk);
    vec++; if (flush_done !== 1'b0 || in_ready !== 1'b0) begin
      errs++; $display("FAIL fp_rearm got done=%b rdy=%b want 0 0", flush_done, in_ready); end
    flush_i = 1'b0;
    @(negedge clk);
    vec++; if (in_ready !== 1'b1) begin errs++; $display("FAIL fp_resume got %b want 1", in_ready); end
    vec++; if (fd_cnt - f0 != 1) begin errs++; $display("FAIL fp_done_count got %0d want 1", fd_cnt - f0); end
  endtask

  task automatic test_flush_empty();
    int q0 = q_data.size();
    @(negedge clk); flush_i = 1'b1;
    @(negedge clk);
    vec++; if (flush_done !== 1'b0) begin errs++; $display("FAIL fe_early got %b want 0", flush_done); end
    @(negedge clk);
    vec++; if (flush_done !== 1'b1 || out_valid !== 1'b0) begin
      errs++; $display("FAIL fe_done got done=%b vld=%b want 1 0", flush_done, out_valid); end
    @(negedge clk);
    vec++; if (flush_done !== 1'b0 || flush_cnt !== 16'd1) begin
      errs++; $display("FAIL fe_after got done=%b cnt=%0d want 0 1", flush_done, flush_cnt); end
    flush_i = 1'b0;
    @(negedge clk);
    vec++; if (in_ready !== 1'b1 || q_data.size() != q0) begin
      errs++; $display("FAIL fe_resume got rdy=%b lines=%0d want 1 0", in_ready, q_data.size() - q0); end
  endtask

  task automatic test_backpressure();
    int q0 = q_data.size();
    logic [255:0] full = mk(64'h13, 64'h12, 64'h11, 64'h10);
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); in_valid = 1'b1;
      in_data = (i < 4) ? 64'h10 + 64'(i) : 64'h20 + 64'(i - 4);
      #1;
      vec++; if (in_ready !== 1'b1) begin errs++; $display("FAIL bp_ready[%0d] got %b want 1", i, in_ready); end
    end
    @(negedge clk); in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      vec++; if (out_valid !== 1'b1 || out_data !== full || out_fill !== 3'd4) begin
        errs++; $display("FAIL bp_stall[%0d] got %b %h/%0d want 1 %h/4", c, out_valid, out_data, out_fill, full); end
    end
    flush_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vec++; if (out_data !== full || flush_done !== 1'b0 || in_ready !== 1'b0) begin
        errs++; $display("FAIL bp_blocked[%0d] got %h done=%b rdy=%b want %h 0 0", c, out_data, flush_done, in_ready, full); end
    end
    out_ready = 1'b1;
    @(negedge clk);
    vec++; if (out_valid !== 1'b1 || out_data !== mk(PAD, PAD, 64'h21, 64'h20) || out_fill !== 3'd2) begin
      errs++; $display("FAIL bp_pad got %b %h/%0d want 1 %h/2", out_valid, out_data, out_fill, mk(PAD, PAD, 64'h21, 64'h20)); end
    @(negedge clk);
    vec++; if (flush_done !== 1'b1 || flush_cnt !== 16'd2) begin
      errs++; $display("FAIL bp_done got done=%b cnt=%0d want 1 2", flush_done, flush_cnt); end
    flush_i = 1'b0;
    repeat (2) @(negedge clk);
    vec++; if (q_data.size() != q0 + 2) begin
      errs++; $display("FAIL bp_lines got %0d want 2", q_data.size() - q0); end
    else begin
      vec++; if (q_data[q0] !== full || q_data[q0+1] !== mk(PAD, PAD, 64'h21, 64'h20) || q_fill[q0+1] !== 3'd2) begin
        errs++; $display("FAIL bp_order got %h then %h/%0d want %h then pad/2", q_data[q0], q_data[q0+1], q_fill[q0+1], full); end
    end
  endtask

  task automatic test_flush_hold();
    int q0 = q_data.size();
    int f0 = fd_cnt;
    out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b1; in_data = 64'h30;
    @(negedge clk); in_data = 64'h31; flush_i = 1'b1;
    #1;
    vec++; if (in_ready !== 1'b0) begin errs++; $display("FAIL fh_ready[0] got %b want 0", in_ready); end
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      vec++; if (in_ready !== 1'b0) begin errs++; $display("FAIL fh_ready[%0d] got %b want 0", c, in_ready); end
    end
    flush_i = 1'b0;
    @(negedge clk);
    vec++; if (in_ready !== 1'b1) begin errs++; $display("FAIL fh_resume got %b want 1", in_ready); end
    for (int i = 2; i < 5; i++) begin
      @(negedge clk); in_data = 64'h30 + 64'(i);
    end
    @(negedge clk); in_valid = 1'b0;
    repeat (3) @(negedge clk);
    vec++; if (fd_cnt - f0 != 1) begin errs++; $display("FAIL fh_done_count got %0d want 1", fd_cnt - f0); end
    vec++; if (q_data.size() != q0 + 2) begin
      errs++; $display("FAIL fh_lines got %0d want 2", q_data.size() - q0); end
    else begin
      vec++; if (q_data[q0] !== mk(PAD, PAD, PAD, 64'h30) || q_fill[q0] !== 3'd1) begin
        errs++; $display("FAIL fh_pad got %h/%0d want %h/1", q_data[q0], q_fill[q0], mk(PAD, PAD, PAD, 64'h30)); end
      vec++; if (q_data[q0+1] !== mk(64'h34, 64'h33, 64'h32, 64'h31) || q_fill[q0+1] !== 3'd4) begin
        errs++; $display("FAIL fh_next got %h/%0d want %h/4", q_data[q0+1], q_fill[q0+1], mk(64'h34, 64'h33, 64'h32, 64'h31)); end
    end
    vec++; if (flush_cnt !== 16'd3) begin errs++; $display("FAIL fh_flush_cnt got %0d want 3", flush_cnt); end
  endtask

  task automatic test_reset_drain();
    int f0 = fd_cnt;
    int q0;
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); in_valid = 1'b1; in_data = 64'h40 + 64'(i);
    end
    @(negedge clk); in_valid = 1'b0; flush_i = 1'b1;
    repeat (2) @(negedge clk);
    vec++; if (out_valid !== 1'b1 || out_fill !== 3'd2) begin
      errs++; $display("FAIL rd_drain got vld=%b fill=%0d want 1 2", out_valid, out_fill); end
    rst_n = 1'b0;
    @(negedge clk);
    vec++; if ({out_valid, opkwenb, flush_done, in_ready} !== 4'b0000) begin
      errs++; $display("FAIL rd_flags got %b want 0000", {out_valid, opkwenb, flush_done, in_ready}); end
    vec++; if (out_data !== '0 || out_fill !== 3'd0 || flush_cnt !== 16'd0) begin
      errs++; $display("FAIL rd_regs got %h/%0d/%0d want 0/0/0", out_data, out_fill, flush_cnt); end
    rst_n = 1'b1; flush_i = 1'b0;
    repeat (4) @(negedge clk);
    vec++; if (fd_cnt - f0 != 0) begin errs++; $display("FAIL rd_no_done got %0d want 0", fd_cnt - f0); end
    q0 = q_data.size();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); in_valid = 1'b1; in_data = 64'h50 + 64'(i);
    end
    @(negedge clk); in_valid = 1'b0;
    repeat (3) @(negedge clk);
    vec++; if (q_data.size() != q0 + 1) begin
      errs++; $display("FAIL rd_lines got %0d want 1", q_data.size() - q0); end
    else begin
      vec++; if (q_data[q0] !== mk(64'h53, 64'h52, 64'h51, 64'h50) || q_fill[q0] !== 3'd4) begin
        errs++; $display("FAIL rd_clean got %h/%0d want %h/4", q_data[q0], q_fill[q0], mk(64'h53, 64'h52, 64'h51, 64'h50)); end
    end
  endtask

  initial begin
    test_reset();
    test_pack();
    test_flush_partial();
    test_flush_empty();
    test_backpressure();
    test_flush_hold();
    test_reset_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
